adder_result_checker: RTL and testbench
=======================================

Name: adder_result_checker

Overview:
Self-checking stage directly downstream of pipelined_adder in the adder test suite. Taps the operands driven into the adder and the adder's sum output, then predicts the exact sum through a valid-tagged delay line matched to the adder latency. Compares every result and reports pass/fail, counts and the first mismatch, so regressions need no waveform inspection.

Parameters:
INP_DW, 3, operand width; must match the adder's INP_DW.
NUM_REG, 2, adder register depth, legal range 1..8; defines the comparison latency.
NUM_CHECKS, 64, number of operand pairs checked per run, range 1..2^16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
inp1  input  INP_DW  operand A as presented to the adder this cycle.
inp2  input  INP_DW  operand B as presented to the adder this cycle.
outp  input  INP_DW+1  adder sum output.
busy  output  1  high in RUN and DRAIN.
done  output  1  high in DONE.
pass  output  1  high in DONE when err_cnt==0; 0 otherwise.
chk_cnt  output  16  number of comparisons performed.
err_cnt  output  16  number of mismatches; saturates at 16'hFFFF.
first_err  output  3*INP_DW+1  {a, b, got} of the first mismatch; 0 if none.

Behaviour:
- Reset (rst_n low, any state, mid-run included): state=IDLE; all outputs 0; delay-line valid bits cleared; issue counter cleared.
- States:
  - IDLE: start moves to RUN, clears the counters and first_err.
  - RUN: samples {inp1, inp2, expected=inp1+inp2 (INP_DW+1 bits, no truncation), valid=1} into stage 1 every cycle. Increments the issue counter. After NUM_CHECKS samples, moves to DRAIN.
  - DRAIN: inserts bubbles (valid=0) until all stages are empty, then moves to DONE.
  - DONE: holds the results. start re-enters RUN with counters cleared.
- Delay line:
  - NUM_REG stages.
  - Operands sampled at edge k reach stage NUM_REG at edge k+NUM_REG-1.
  - At edge k+NUM_REG, stage NUM_REG is compared against outp, which is the adder's registered result of the edge-k operands.
- Compare occurs only when the last stage is valid. Invalid stages never count, which masks the adder's unreset X contents.
- On compare: chk_cnt+1. On mismatch: err_cnt+1 (saturating). first_err is captured only if err_cnt was 0.
- outp containing X or Z counts as a mismatch (case-inequality compare in simulation).
- Run length: exactly NUM_CHECKS+NUM_REG cycles from the first RUN cycle to DONE entry.
- start while busy: ignored; no restart and no counter effect.
- Register outputs only. No combinational path from inputs to outputs.

Optional Feature:
Macro ADDER_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatch forces an immediate transition to DONE. Remaining issues and pipeline contents are discarded. chk_cnt stops at the failing compare.
- Undefined: the run always completes all NUM_CHECKS compares and counts every error.

Decomposition:
- Shared package adder_tb_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE (2 bits);
  - CNT_W=16 and the err_cnt saturation value.
- One sub-module, chk_delay_line: a NUM_REG-deep shift register of {valid, a, b, expected} with asynchronous clear of the valid bits.
- Top level holds the FSM, counters, comparator and first_err capture.

Test Plan:
- Exhaustive sweep, INP_DW=3, NUM_REG=2, NUM_CHECKS=64, a/b stepping through all 64 pairs against a correct adder -> DONE after 66 cycles; chk_cnt=64, err_cnt=0, pass=1.
- Injected fault: the adder model returns 4'd0 when a=3'd7 and b=3'd1 -> err_cnt=1, first_err={3'd7, 3'd1, 4'd0}, pass=0.
- Latency sweep with NUM_REG=1, 4 and 8, operands 7+7 -> expected 4'd14; each run passes; done asserts exactly NUM_CHECKS+NUM_REG cycles after start.
- Reset mid-run: rst_n low during RUN at chk_cnt=10 -> all outputs 0 asynchronously, state IDLE; a later start gives a clean pass.
- start pulsed during DRAIN -> ignored; chk_cnt still finishes at 64.
- With ADDER_CHK_STOP_ON_ERR_EN defined, fault injected on the 5th compare -> done asserts at the next edge; chk_cnt=5, err_cnt=1.

Source files
------------

// File: rtl/adder_tb_pkg.sv
// Shared constants for the adder result checker: FSM state encoding and counter sizing.
package adder_tb_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] ERR_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/chk_delay_line.sv
// Valid-tagged shift register carrying {a, b, expected} to line up with the adder latency.
// Stage 1 sits in the low slice of the packed vectors; the last stage is the top slice.
module chk_delay_line #(
  parameter int INP_DW  = 3,
  parameter int NUM_REG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [INP_DW-1:0] a_i,
  input  logic [INP_DW-1:0] b_i,
  input  logic [INP_DW:0]   exp_i,
  output logic              valid_o,
  output logic [INP_DW-1:0] a_o,
  output logic [INP_DW-1:0] b_o,
  output logic [INP_DW:0]   exp_o,
  output logic              upper_busy_o
);

  localparam int DW = 3 * INP_DW + 1;

  logic [NUM_REG-1:0]    vld_q;
  logic [NUM_REG*DW-1:0] data_q;
  logic [DW-1:0]         last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= NUM_REG'({vld_q, valid_i});
    end
  end

  // Payload is left unreset; only the valid bits decide whether a stage is compared.
  always_ff @(posedge clk) begin
    data_q <= (NUM_REG*DW)'({data_q, a_i, b_i, exp_i});
  end

  assign last         = data_q[NUM_REG*DW-1 -: DW];
  assign valid_o      = vld_q[NUM_REG-1];
  assign a_o          = last[DW-1 -: INP_DW];
  assign b_o          = last[INP_DW+INP_DW : INP_DW+1];
  assign exp_o        = last[INP_DW:0];
  assign upper_busy_o = |(vld_q & ~(NUM_REG'(1) << (NUM_REG - 1)));

endmodule

// File: rtl/adder_result_checker.sv
// Checks pipelined_adder sums against a latency-matched prediction and reports counts/first error.
// Define ADDER_CHK_STOP_ON_ERR_EN to end a run at the first mismatch.
//
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start
//   ST_RUN   | issuing one operand pair per cycle into the delay line
//   ST_DRAIN | issuing bubbles until the delay line is empty
//   ST_DONE  | results held; start begins a new run
module adder_result_checker
  import adder_tb_pkg::*;
#(
  parameter int INP_DW     = 3,
  parameter int NUM_REG    = 2,
  parameter int NUM_CHECKS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [INP_DW-1:0] inp1,
  input  logic [INP_DW-1:0] inp2,
  input  logic [INP_DW:0]   outp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  chk_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [3*INP_DW:0] first_err
);

  localparam int ISS_W = CNT_W + 1;

  chk_state_e        state_q, state_d;
  logic [ISS_W-1:0]  iss_q, iss_d;
  logic [CNT_W-1:0]  chk_q, chk_d, err_q, err_d;
  logic [3*INP_DW:0] ferr_q, ferr_d;
  logic              busy_q, done_q, pass_q;

  logic              sample_en, flush, start_ok, upper_busy, mismatch;
  logic              last_vld;
  logic [INP_DW-1:0] last_a, last_b;
  logic [INP_DW:0]   last_exp, exp_in;

  assign exp_in    = {1'b0, inp1} + {1'b0, inp2};
  assign sample_en = (state_q == ST_RUN);
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Case inequality so an X/Z adder output is reported rather than silently matching.
  assign mismatch  = last_vld && (outp !== last_exp);

  chk_delay_line #(
    .INP_DW  (INP_DW),
    .NUM_REG (NUM_REG)
  ) u_delay (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .valid_i      (sample_en),
    .a_i          (inp1),
    .b_i          (inp2),
    .exp_i        (exp_in),
    .valid_o      (last_vld),
    .a_o          (last_a),
    .b_o          (last_b),
    .exp_o        (last_exp),
    .upper_busy_o (upper_busy)
  );

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          iss_d   = ISS_W'(NUM_CHECKS);
        end
      end
      ST_RUN: begin
        iss_d = iss_q - 1'b1;
        if (iss_q == ISS_W'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!upper_busy) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    if (mismatch) begin
      state_d = ST_DONE;
      iss_d   = '0;
      flush   = 1'b1;
    end
`endif
  end

  always_comb begin
    chk_d  = chk_q;
    err_d  = err_q;
    ferr_d = ferr_q;
    if (start_ok) begin
      chk_d  = '0;
      err_d  = '0;
      ferr_d = '0;
    end else if (last_vld) begin
      chk_d = chk_q + 1'b1;
      if (mismatch) begin
        if (err_q != ERR_SAT) err_d = err_q + 1'b1;
        if (err_q == '0)      ferr_d = {last_a, last_b, outp};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iss_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
      pass_q  <= (state_d == ST_DONE) && (err_d == '0);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign chk_cnt   = chk_q;
  assign err_cnt   = err_q;
  assign first_err = ferr_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench: four checker instances (NUM_REG 2/1/4/8) fed by behavioural adder pipelines
// with an optional injected wrong sum.
module tb_adder_result_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] start_v = '0;
  logic [2:0] inp1 = '0;
  logic [2:0] inp2 = '0;
  logic       fault_en = 1'b0;
  logic [2:0] fault_a = '0;
  logic [2:0] fault_b = '0;

  logic [3:0]       busy_v, done_v, pass_v;
  logic [3:0][15:0] chk_v, err_v;
  logic [3:0][9:0]  ferr_v;

  logic [3:0] sum_in;
  logic [3:0] p1 [1];
  logic [3:0] p2 [2];
  logic [3:0] p4 [4];
  logic [3:0] p8 [8];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    sum_in = {1'b0, inp1} + {1'b0, inp2};
    if (fault_en && inp1 == fault_a && inp2 == fault_b) sum_in = 4'd0;
  end

  always @(posedge clk) begin
    p1[0] <= sum_in;
    p2[0] <= sum_in;
    p4[0] <= sum_in;
    p8[0] <= sum_in;
    p2[1] <= p2[0];
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    for (int i = 1; i < 8; i++) p8[i] <= p8[i-1];
  end

  adder_result_checker #(.INP_DW(3), .NUM_REG(2), .NUM_CHECKS(64)) u_r2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .inp1(inp1), .inp2(inp2), .outp(p2[1]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .chk_cnt(chk_v[0]), .err_cnt(err_v[0]), .first_err(ferr_v[0]));

  adder_result_checker #(.INP_DW(3), .NUM_REG(1), .NUM_CHECKS(8)) u_r1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .inp1(inp1), .inp2(inp2), .outp(p1[0]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .chk_cnt(chk_v[1]), .err_cnt(err_v[1]), .first_err(ferr_v[1]));

  adder_result_checker #(.INP_DW(3), .NUM_REG(4), .NUM_CHECKS(8)) u_r4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .inp1(inp1), .inp2(inp2), .outp(p4[3]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .chk_cnt(chk_v[2]), .err_cnt(err_v[2]), .first_err(ferr_v[2]));

  adder_result_checker #(.INP_DW(3), .NUM_REG(8), .NUM_CHECKS(8)) u_r8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .inp1(inp1), .inp2(inp2), .outp(p8[7]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
    .chk_cnt(chk_v[3]), .err_cnt(err_v[3]), .first_err(ferr_v[3]));

  // Pulses start on instance w, then feeds n operand pairs (sweep or 7+7), one per edge.
  // done_cyc = edges after the start edge until done is seen; -1 if it never shows.
  task automatic run(input int w, input int n, input bit const77, input int pulse_at,
                     input int abort_at, output int done_cyc);
    done_cyc = -1;
    start_v[w] = 1'b1;
    @(posedge clk); #1;
    start_v[w] = 1'b0;
    for (int j = 1; j <= n + 40; j++) begin
      if (j - 1 < n) begin
        if (const77) begin
          inp1 = 3'd7;
          inp2 = 3'd7;
        end else begin
          inp1 = 3'((j - 1) >> 3);
          inp2 = 3'(j - 1);
        end
      end else begin
        inp1 = '0;
        inp2 = '0;
      end
      start_v[w] = (j == pulse_at);
      @(posedge clk); #1;
      start_v[w] = 1'b0;
      if (j == abort_at) return;
      if (done_v[w]) begin
        done_cyc = j;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_v[0]); end
    n_cmp++; if (done_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_v[0]); end
    n_cmp++; if (pass_v[0] !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b want 0", pass_v[0]); end
    n_cmp++; if (chk_v[0] !== 16'd0) begin n_err++; $display("FAIL reset_chk: got %0d want 0", chk_v[0]); end
    n_cmp++; if (err_v[0] !== 16'd0) begin n_err++; $display("FAIL reset_err: got %0d want 0", err_v[0]); end
    n_cmp++; if (ferr_v[0] !== 10'd0) begin n_err++; $display("FAIL reset_ferr: got %0h want 0", ferr_v[0]); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int dc;
    run(0, 64, 1'b0, 0, 0, dc);
    n_cmp++; if (dc != 66) begin n_err++; $display("FAIL sweep_latency: got %0d want 66", dc); end
    n_cmp++; if (chk_v[0] !== 16'd64) begin n_err++; $display("FAIL sweep_chk: got %0d want 64", chk_v[0]); end
    n_cmp++; if (err_v[0] !== 16'd0) begin n_err++; $display("FAIL sweep_err: got %0d want 0", err_v[0]); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_err++; $display("FAIL sweep_pass: got %b want 1", pass_v[0]); end
    n_cmp++; if (ferr_v[0] !== 10'd0) begin n_err++; $display("FAIL sweep_ferr: got %0h want 0", ferr_v[0]); end
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL sweep_busy: got %b want 0", busy_v[0]); end
  endtask

  task automatic test_fault();
    int dc;
    int exp_dc;
    logic [15:0] exp_chk;
    logic [9:0]  exp_fe;
    exp_fe = {3'd7, 3'd1, 4'd0};
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    exp_dc = 60;
    exp_chk = 16'd58;
`else
    exp_dc = 66;
    exp_chk = 16'd64;
`endif
    fault_en = 1'b1; fault_a = 3'd7; fault_b = 3'd1;
    run(0, 64, 1'b0, 0, 0, dc);
    fault_en = 1'b0;
    n_cmp++; if (dc != exp_dc) begin n_err++; $display("FAIL fault_latency: got %0d want %0d", dc, exp_dc); end
    n_cmp++; if (chk_v[0] !== exp_chk) begin n_err++; $display("FAIL fault_chk: got %0d want %0d", chk_v[0], exp_chk); end
    n_cmp++; if (err_v[0] !== 16'd1) begin n_err++; $display("FAIL fault_err: got %0d want 1", err_v[0]); end
    n_cmp++; if (ferr_v[0] !== exp_fe) begin n_err++; $display("FAIL fault_ferr: got %0h want %0h", ferr_v[0], exp_fe); end
    n_cmp++; if (pass_v[0] !== 1'b0) begin n_err++; $display("FAIL fault_pass: got %b want 0", pass_v[0]); end
  endtask

  task automatic test_restart();
    int c;
    start_v[0] = 1'b1;
    inp1 = '0; inp2 = '0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n_cmp++; if (err_v[0] !== 16'd0) begin n_err++; $display("FAIL restart_err_clr: got %0d want 0", err_v[0]); end
    n_cmp++; if (ferr_v[0] !== 10'd0) begin n_err++; $display("FAIL restart_ferr_clr: got %0h want 0", ferr_v[0]); end
    n_cmp++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b want 1", busy_v[0]); end
    n_cmp++; if (done_v[0] !== 1'b0) begin n_err++; $display("FAIL restart_done: got %b want 0", done_v[0]); end
    c = -1;
    for (int j = 1; j <= 120; j++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin c = j; break; end
    end
    n_cmp++; if (c != 66) begin n_err++; $display("FAIL restart_latency: got %0d want 66", c); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_err++; $display("FAIL restart_pass: got %b want 1", pass_v[0]); end
  endtask

  task automatic test_latency();
    int dc;
    int r;
    for (int w = 1; w < 4; w++) begin
      r = (w == 1) ? 1 : (w == 2) ? 4 : 8;
      run(w, 8, 1'b1, 0, 0, dc);
      n_cmp++; if (dc != 8 + r) begin n_err++; $display("FAIL latency_r%0d: got %0d want %0d", r, dc, 8 + r); end
      n_cmp++; if (chk_v[w] !== 16'd8) begin n_err++; $display("FAIL latency_chk_r%0d: got %0d want 8", r, chk_v[w]); end
      n_cmp++; if (err_v[w] !== 16'd0) begin n_err++; $display("FAIL latency_err_r%0d: got %0d want 0", r, err_v[w]); end
      n_cmp++; if (pass_v[w] !== 1'b1) begin n_err++; $display("FAIL latency_pass_r%0d: got %b want 1", r, pass_v[w]); end
    end
  endtask

  task automatic test_start_while_busy();
    int dc;
    run(0, 64, 1'b0, 65, 0, dc);
    n_cmp++; if (dc != 66) begin n_err++; $display("FAIL drain_start_latency: got %0d want 66", dc); end
    n_cmp++; if (chk_v[0] !== 16'd64) begin n_err++; $display("FAIL drain_start_chk: got %0d want 64", chk_v[0]); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_err++; $display("FAIL drain_start_pass: got %b want 1", pass_v[0]); end
    run(0, 64, 1'b0, 30, 0, dc);
    n_cmp++; if (dc != 66) begin n_err++; $display("FAIL run_start_latency: got %0d want 66", dc); end
    n_cmp++; if (chk_v[0] !== 16'd64) begin n_err++; $display("FAIL run_start_chk: got %0d want 64", chk_v[0]); end
  endtask

  task automatic test_reset_mid_run();
    int dc;
    run(0, 64, 1'b0, 0, 12, dc);
    n_cmp++; if (chk_v[0] !== 16'd10) begin n_err++; $display("FAIL midrun_chk_before: got %0d want 10", chk_v[0]); end
    n_cmp++; if (busy_v[0] !== 1'b1) begin n_err++; $display("FAIL midrun_busy_before: got %b want 1", busy_v[0]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL midrun_busy: got %b want 0", busy_v[0]); end
    n_cmp++; if (done_v[0] !== 1'b0) begin n_err++; $display("FAIL midrun_done: got %b want 0", done_v[0]); end
    n_cmp++; if (chk_v[0] !== 16'd0) begin n_err++; $display("FAIL midrun_chk: got %0d want 0", chk_v[0]); end
    n_cmp++; if (ferr_v[0] !== 10'd0) begin n_err++; $display("FAIL midrun_ferr: got %0h want 0", ferr_v[0]); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL midrun_idle: got busy %b want 0", busy_v[0]); end
    run(0, 64, 1'b0, 0, 0, dc);
    n_cmp++; if (dc != 66) begin n_err++; $display("FAIL midrun_rerun_latency: got %0d want 66", dc); end
    n_cmp++; if (chk_v[0] !== 16'd64) begin n_err++; $display("FAIL midrun_rerun_chk: got %0d want 64", chk_v[0]); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_err++; $display("FAIL midrun_rerun_pass: got %b want 1", pass_v[0]); end
  endtask

  task automatic test_stop_on_err();
    int dc;
    int exp_dc;
    logic [15:0] exp_chk;
    logic [9:0]  exp_fe;
    exp_fe = {3'd0, 3'd4, 4'd0};
`ifdef ADDER_CHK_STOP_ON_ERR_EN
    exp_dc = 7;
    exp_chk = 16'd5;
`else
    exp_dc = 66;
    exp_chk = 16'd64;
`endif
    fault_en = 1'b1; fault_a = 3'd0; fault_b = 3'd4;
    run(0, 64, 1'b0, 0, 0, dc);
    fault_en = 1'b0;
    n_cmp++; if (dc != exp_dc) begin n_err++; $display("FAIL stop_latency: got %0d want %0d", dc, exp_dc); end
    n_cmp++; if (chk_v[0] !== exp_chk) begin n_err++; $display("FAIL stop_chk: got %0d want %0d", chk_v[0], exp_chk); end
    n_cmp++; if (err_v[0] !== 16'd1) begin n_err++; $display("FAIL stop_err: got %0d want 1", err_v[0]); end
    n_cmp++; if (ferr_v[0] !== exp_fe) begin n_err++; $display("FAIL stop_ferr: got %0h want %0h", ferr_v[0], exp_fe); end
    run(0, 64, 1'b0, 0, 0, dc);
    n_cmp++; if (dc != 66) begin n_err++; $display("FAIL stop_rerun_latency: got %0d want 66", dc); end
    n_cmp++; if (chk_v[0] !== 16'd64) begin n_err++; $display("FAIL stop_rerun_chk: got %0d want 64", chk_v[0]); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_err++; $display("FAIL stop_rerun_pass: got %b want 1", pass_v[0]); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_fault();
    test_restart();
    test_latency();
    test_start_while_busy();
    test_reset_mid_run();
    test_stop_on_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
